// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: runs the instruction-memory read handshake and issues PS/PC_IN
// commands to the program counter. Optional fetch watchdog: define FETCH_TIMEOUT_EN.
module pc_fetch_sequencer #(
  parameter int ADDR_W      = 64,
  parameter int INSTR_W     = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               stall,
  output logic [1:0]         PS,
  output logic [ADDR_W-1:0]  PC_IN,
  output logic [INSTR_W-1:0] instr,
`ifdef FETCH_TIMEOUT_EN
  output logic               instr_valid,
  output logic               fetch_err
`else
  output logic               instr_valid
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  localparam logic [5:0] OP_B = 6'b000101;

  state_t              state;
  logic                first_cyc;
  logic [ADDR_W-1:0]   addr_q;
  logic                handoff;
  logic                locked;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;
  assign locked = fetch_err;
`else
  assign locked = 1'b0;
`endif

  // The PC only settles on the new value after the handoff edge, so the first
  // FETCH cycle forwards pc directly and the address is captured for the rest of the wait.
  assign mem_addr = first_cyc ? pc : addr_q;
  assign handoff  = (state == ISSUE) && !stall;

  always_comb begin
    PS    = 2'b00;
    PC_IN = '0;
    if (handoff) begin
      if (redirect) begin
        PS    = 2'b10;
        PC_IN = redirect_addr;
      end else if (instr[31:26] == OP_B) begin
        PS    = 2'b11;
        PC_IN = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
      end else begin
        PS    = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      first_cyc   <= 1'b0;
      addr_q      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wd_cnt      <= '0;
      fetch_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run && !locked) begin
            state     <= FETCH;
            mem_req   <= 1'b1;
            first_cyc <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        FETCH: begin
          first_cyc <= 1'b0;
          if (first_cyc) addr_q <= pc;
          if (mem_ack) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= ISSUE;
`ifdef FETCH_TIMEOUT_EN
          end else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (run) begin
              state     <= FETCH;
              mem_req   <= 1'b1;
              first_cyc <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              wd_cnt    <= '0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Drives the select/data side of the program counter. Consumes the PC value, runs a memory-read handshake to fetch the instruction, then issues the PS/PC_IN command for the next PC value.
- Sits between the program counter, instruction memory and decode.
- Generates PS codes: 00 hold, 01 increment by 4, 10 load PC_IN, 11 add PC_IN offset.

Parameters:
ADDR_W, 64, width of PC, memory address, PC_IN and redirect target
INSTR_W, 32, instruction width
TIMEOUT_CYC, 16, fetch watchdog limit in cycles; used only with FETCH_TIMEOUT_EN

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
run  input  1  level; 1 = sequencer fetches continuously
pc  input  ADDR_W  current PC_OUT from program counter
mem_req  output  1  instruction read request
mem_addr  output  ADDR_W  read address
mem_ack  input  1  read complete; mem_rdata valid this cycle
mem_rdata  input  INSTR_W  instruction word
redirect  input  1  execute-stage absolute jump request
redirect_addr  input  ADDR_W  absolute jump target
stall  input  1  downstream not ready to accept instr
PS  output  2  program counter select
PC_IN  output  ADDR_W  program counter data
instr  output  INSTR_W  fetched instruction
instr_valid  output  1  instr valid and offered downstream
fetch_err  output  1  sticky watchdog error; exists only with FETCH_TIMEOUT_EN

Behaviour:
- Reset (rst=0, async): state IDLE. PS=00, PC_IN=0, mem_req=0, mem_addr=0, instr=0, instr_valid=0, fetch_err=0.
- Reset mid-handshake abandons the request immediately. A late mem_ack is ignored because the state is IDLE.
- States: IDLE, FETCH, ISSUE.
- IDLE: PS=00, mem_req=0. If run=1, go to FETCH on the next edge.
- FETCH:
  - mem_req=1; mem_addr registered from pc on entry and held stable until ack.
  - PS=00.
  - On the cycle with mem_ack=1: register mem_rdata into instr, set instr_valid=1, go to ISSUE.
  - mem_ack in a cycle with mem_req=0 is ignored.
  - Zero-wait memory (ack in the first FETCH cycle) is legal: 2 cycles per instruction minimum.
- ISSUE (PS/PC_IN combinational from registered instr and inputs):
  - If stall=1: PS=00, remain in ISSUE, instr and instr_valid held.
  - Else, in priority order:
    - redirect=1 -> PS=10, PC_IN=redirect_addr.
    - instr[31:26]==6'b000101 (B) -> PS=11, PC_IN = sign-extended instr[25:0] shifted left 2, at ADDR_W bits.
    - otherwise -> PS=01, PC_IN=0.
  - The non-stalled ISSUE cycle is the handoff cycle. On that edge the PC updates, instr_valid clears, and state goes to FETCH if run=1, else IDLE.
  - PS is non-00 for exactly one cycle per instruction.
- run deassert mid-FETCH: the current fetch completes and issues, then the sequencer returns to IDLE. No request is abandoned.
- redirect outside a non-stalled ISSUE cycle is ignored. The source holds it until taken.
- PC arithmetic (including wrap-around of negative offsets) is owned by the program counter. PC_IN carries the raw signed offset.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without mem_ack.
  - When it reaches TIMEOUT_CYC: drop mem_req, set fetch_err=1 (sticky until reset), go to IDLE.
  - IDLE then stays put regardless of run until reset.
  - mem_ack in the same cycle as the limit wins; no error is raised.
- Undefined: no counter and no fetch_err port; FETCH waits indefinitely.

Test Plan:
- Reset: rst=0 while run=1 and mem_req=1 -> all outputs 0 within the same cycle; no PS pulse after release until run and ack.
- Sequential fetch: pc=0, run=1, memory acks after 1 wait cycle with non-branch words -> mem_addr 0,4,8; PS=01 one cycle each; instr_valid pulses with the matching words.
- Branch: mem_rdata=0x14000004 (B +4 words) at pc=8 -> PS=11, PC_IN=16; next mem_addr=24. Backward B with imm26=0x3FFFFFE -> PC_IN=0xFFFFFFFFFFFFFFF8.
- Redirect priority: redirect=1, redirect_addr=0x40 during ISSUE of a B instruction -> PS=10, PC_IN=0x40, next mem_addr=0x40.
- Stall/run: stall=1 for 3 cycles in ISSUE -> PS=00, instr held, no new mem_req. run=0 mid-FETCH -> ack honoured, one PS=01, then IDLE with mem_req=0.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=16: no ack -> mem_req drops after 16 cycles, fetch_err=1, sequencer stays idle. Ack on cycle 16 -> normal issue, fetch_err=0.
